// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment bus: segment codes, blank pattern, monitor FSM states.
// Codes are active-low with segments a..g in bits 7..1 and dp in bit 0 (shown as 1).
package seg7_pkg;

  localparam int unsigned DEFAULT_STABLE_CYCLES = 4;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Index i holds the pattern for hex value i.
  localparam logic [7:0] SEG_CODE [16] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'h11, 8'hC1, 8'hE5, 8'h85, 8'h61, 8'h71
  };

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETTLING = 2'd1,
    ST_STABLE   = 2'd2
  } state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational decode of segments a..g (dp excluded) into a hex value.
// is_valid_o flags one of the 16 known codes; is_blank_o flags all segments off.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] value_o,
  output logic       is_valid_o,
  output logic       is_blank_o
);

  always_comb begin
    value_o    = 4'h0;
    is_valid_o = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg_i == SEG_CODE[i][7:1]) begin
        value_o    = 4'(i);
        is_valid_o = 1'b1;
      end
    end
    is_blank_o = (seg_i == SEG_BLANK[7:1]);
  end

endmodule

// File: rtl/seg7_digit_monitor.sv
// Glitch-filtering monitor for an active-low 7-segment bus: decodes stable patterns to hex digits.
// Build with SEG7_SEQ_CHECK_EN defined to flag digits that break the 0..9 roulette order.
module seg7_digit_monitor
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seg_in,
  output logic [3:0] digit_out,
  output logic       digit_valid,
  output logic       pattern_err,
  output logic       seq_err,
  output logic [7:0] digit_count
);

  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

  logic [7:0] s_reg_q;
  logic [7:0] cand_q, cand_d;
  logic [7:0] cnt_q, cnt_d;
  logic [6:0] acc_q, acc_d;
  state_e     state_q, state_d;
  logic [3:0] digit_q, digit_d;
  logic       dv_q, dv_d;
  logic       pe_q, pe_d;
  logic [7:0] count_q, count_d;

  logic [3:0] dec_value;
  logic       dec_valid;
  logic       dec_blank;

  seg7_pattern_decode u_decode (
    .seg_i      (cand_q[7:1]),
    .value_o    (dec_value),
    .is_valid_o (dec_valid),
    .is_blank_o (dec_blank)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s_reg_q <= SEG_BLANK;
      cand_q  <= SEG_BLANK;
      cnt_q   <= 8'd0;
      acc_q   <= SEG_BLANK[7:1];
      state_q <= ST_IDLE;
      digit_q <= 4'h0;
      dv_q    <= 1'b0;
      pe_q    <= 1'b0;
      count_q <= 8'd0;
    end else begin
      s_reg_q <= seg_in;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      state_q <= state_d;
      digit_q <= digit_d;
      dv_q    <= dv_d;
      pe_q    <= pe_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    state_d = state_q;
    digit_d = digit_q;
    dv_d    = 1'b0;
    pe_d    = 1'b0;
    count_d = count_q;
    // Any change, including dp alone, restarts the settle window.
    if (s_reg_q != cand_q) begin
      cand_d  = s_reg_q;
      cnt_d   = 8'd0;
      state_d = ST_SETTLING;
    end else if (state_q == ST_SETTLING) begin
      if (cnt_q == CNT_LAST) begin
        acc_d = cand_q[7:1];
        if (cand_q[7:1] == acc_q) begin
          state_d = ST_STABLE;
        end else if (dec_blank) begin
          state_d = ST_IDLE;
        end else if (dec_valid) begin
          digit_d = dec_value;
          dv_d    = 1'b1;
          count_d = count_q + 8'd1;
          state_d = ST_STABLE;
        end else begin
          pe_d    = 1'b1;
          state_d = ST_STABLE;
        end
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

`ifdef SEG7_SEQ_CHECK_EN
  logic [3:0] prev_q;
  logic       have_prev_q;
  logic       se_q;
  logic [3:0] succ;

  // Anything at or past 9 may only be followed by 0.
  assign succ = (prev_q >= 4'd9) ? 4'd0 : prev_q + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q      <= 4'h0;
      have_prev_q <= 1'b0;
      se_q        <= 1'b0;
    end else begin
      se_q <= dv_d && have_prev_q && (dec_value != succ);
      if (dv_d) begin
        prev_q      <= dec_value;
        have_prev_q <= 1'b1;
      end
    end
  end

  assign seq_err = se_q;
`else
  assign seq_err = 1'b0;
`endif

  assign digit_out   = digit_q;
  assign digit_valid = dv_q;
  assign pattern_err = pe_q;
  assign digit_count = count_q;

endmodule
